// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the coil PWM controller and the coil model.
//   pwm_state_e    : controller FSM states, encoding visible on the state output.
//   IEST_XOR_MASK  : the ADC current estimate is inverted; XOR with this mask to get signed DN.
//   IEST_DN_PER_A  : current scale, 205 DN per amp.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_FAULT = 2'd3
  } pwm_state_e;

  localparam logic [11:0] IEST_XOR_MASK = 12'h7FF;
  localparam int          IEST_DN_PER_A = 205;

endpackage

// File: rtl/iest_decode.sv
// iest_decode: combinational decode of the inverted 12-bit current estimate into an
// unsigned 11-bit magnitude. Negative currents are clamped to 0.
//   i_iest : raw ADC-format estimate (0 A = 0x7FF)
//   o_meas : decoded current, unsigned DN
module iest_decode
  import pwm_pkg::*;
(
  input  logic [11:0] i_iest,
  output logic [10:0] o_meas
);

  logic [11:0] w_raw;

  assign w_raw  = i_iest ^ IEST_XOR_MASK;
  // bit 11 is the sign after the XOR; anything negative reads as 0 A
  assign o_meas = w_raw[11] ? 11'd0 : w_raw[10:0];

endmodule

// File: rtl/pwm_hysteresis_ctrl.sv
// pwm_hysteresis_ctrl: peak/valley hysteresis current controller for a coil driver,
// with minimum on/off times and a max-on fault.
//   clk, reset_n      : clock, asynchronous active-low reset
//   enable            : run request (level)
//   iest_coil         : estimated coil current, inverted ADC format
//   i_peak, i_valley  : turn-off / turn-on thresholds, unsigned DN
//   fault_clr         : clears FAULT when enable is low
//   pwm               : switch drive, high only in ON
//   state             : current FSM state
//   fault             : sticky max-on fault
//   pulse_cnt         : saturating count of ON entries
module pwm_hysteresis_ctrl
  import pwm_pkg::*;
#(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8,
  parameter int MAX_ON  = 240
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] iest_coil,
  input  logic [10:0] i_peak,
  input  logic [10:0] i_valley,
  input  logic        fault_clr,
  output logic        pwm,
  output logic [1:0]  state,
  output logic        fault,
  output logic [15:0] pulse_cnt
);

  // phase counter reads N-1 in the Nth cycle of a state
  localparam logic [7:0] C_MIN_ON  = 8'(MIN_ON - 1);
  localparam logic [7:0] C_MIN_OFF = 8'(MIN_OFF - 1);
  localparam logic [7:0] C_MAX_ON  = 8'(MAX_ON - 1);

  pwm_state_e  r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_pwm;
  logic        r_fault;
  logic [15:0] r_pulse;
  logic        r_armed;
  logic [10:0] w_meas;

  iest_decode u_dec (
    .i_iest (iest_coil),
    .o_meas (w_meas)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      // r_armed holds IDLE through the first edge after reset release
      ST_IDLE:  if (enable && !r_fault && r_armed) w_next = ST_ON;
      ST_ON: begin
        if (r_cnt == C_MAX_ON)
          w_next = ST_FAULT;
        else if (r_cnt >= C_MIN_ON && (w_meas >= i_peak || !enable))
          w_next = ST_OFF;
      end
      ST_OFF: begin
        if (r_cnt >= C_MIN_OFF) begin
          if (!enable)                 w_next = ST_IDLE;
          else if (w_meas <= i_valley) w_next = ST_ON;
        end
      end
      ST_FAULT: if (fault_clr && !enable) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_pwm   <= 1'b0;
      r_fault <= 1'b0;
      r_pulse <= 16'd0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_state <= w_next;
      r_pwm   <= (w_next == ST_ON);
      r_fault <= (w_next == ST_FAULT);
      if (w_next != r_state)  r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (w_next == ST_ON && r_state != ST_ON && r_pulse != 16'hFFFF)
        r_pulse <= r_pulse + 16'd1;
    end
  end

  assign pwm       = r_pwm;
  assign state     = r_state;
  assign fault     = r_fault;
  assign pulse_cnt = r_pulse;

endmodule

// File: doc/pwm_hysteresis_ctrl.md
PWM_HYSTERESIS_CTRL -- requirements
Module: pwm_hysteresis_ctrl

Interface
REQ-001 SHALL have parameter MIN_ON, default 8, meaning the minimum PWM high time in clk cycles.
REQ-002 SHALL have parameter MIN_OFF, default 8, meaning the minimum PWM low time in clk cycles.
REQ-003 SHALL have parameter MAX_ON, default 240, meaning the PWM high time in clk cycles at which the block declares a fault.
REQ-004 SHALL have ports:
- clk  in  1  48 MHz clock.
- reset_n  in  1  asynchronous reset, active low.
- enable  in  1  run request; level.
- iest_coil  in  12  estimated coil current; ADC-native inverted format, 205 DN/A, 0 A = 0x7FF.
- i_peak  in  11  turn-off threshold; unsigned DN, 205 DN/A.
- i_valley  in  11  turn-on threshold; unsigned DN.
- fault_clr  in  1  single-cycle pulse that clears the fault.
- pwm  out  1  power switch drive; this is the signal consumed by the coil model.
- state  out  2  current FSM state.
- fault  out  1  sticky max-on fault flag.
- pulse_cnt  out  16  count of ON entries; saturating.

Function
REQ-005 SHALL decode the current each cycle as i_meas = signed(iest_coil XOR 0x7FF), clamping negative values to 0, into an 11-bit unsigned value.
REQ-006 SHALL implement states IDLE=0, ON=1, OFF=2 and FAULT=3, with pwm registered and equal to 1 only in ON.
REQ-007 SHALL use an 8-bit phase counter that clears on every state change and otherwise increments, saturating at 255.
REQ-008 SHALL make these transitions from IDLE:
- enable=1 and fault=0 -> ON.
- otherwise stay in IDLE.
REQ-009 SHALL make these transitions from ON, in priority order:
- cnt = MAX_ON-1 -> FAULT.
- cnt >= MIN_ON-1 and (i_meas >= i_peak or enable=0) -> OFF.
- otherwise stay in ON.
REQ-010 SHALL make these transitions from OFF:
- cnt >= MIN_OFF-1 and enable=0 -> IDLE.
- cnt >= MIN_OFF-1 and i_meas <= i_valley -> ON.
- otherwise stay in OFF.
REQ-011 SHALL treat FAULT as follows:
- pwm=0 and fault=1.
- leave to IDLE only in a cycle where fault_clr=1 and enable=0.
- fault_clr while enable=1 is ignored.
REQ-012 SHALL change pwm on the clock edge after the cycle in which the transition condition is true, i.e. one cycle of latency from iest_coil to pwm.
REQ-013 SHALL guarantee:
- every high pulse lasts at least MIN_ON and at most MAX_ON cycles.
- every low pulse between two high pulses lasts at least MIN_OFF cycles.
- both hold regardless of input glitches.
REQ-014 SHALL handle i_peak <= i_valley by obeying the transition rules literally, with no special case, so the block oscillates at the minimum-time limits.
REQ-015 SHALL increment pulse_cnt on each entry to ON, holding at 0xFFFF.
REQ-016 SHALL let the ON-exit rules take priority if enable drops mid-pulse, so pwm is never cut short of MIN_ON.

Reset
REQ-017 SHALL, while reset_n=0, asynchronously force:
- state = IDLE and pwm = 0.
- fault = 0, pulse_cnt = 0 and cnt = 0.
REQ-018 SHALL force pwm low within the asserting edge of reset_n mid-pulse, without waiting for a clock edge.
REQ-019 SHALL exit reset synchronously, leaving IDLE no earlier than the first clk edge after reset_n rises.

Structure
REQ-020 SHALL take the FSM state enum and the current-decode constants (0x7FF XOR mask, 205 DN/A) from a shared package, pwm_pkg, also used by model_coil users.
REQ-021 SHALL place the current decode/clamp in a sub-module, iest_decode, which is combinational.

Verification
REQ-022 SHALL cover peak turn-off: enable=1, i_peak=410 (2 A), i_valley=205, iest_coil ramped from 0x7FF down to 0x665 after 20 cycles -> pwm falls one cycle after iest_coil=0x665; pulse_cnt=1.
REQ-023 SHALL cover valley turn-on: in OFF, iest_coil held at 0x665 for 30 cycles, then set to 0x732 (1 A) -> pwm rises the next cycle; pulse_cnt=2.
REQ-024 SHALL cover the min-on limit: iest_coil=0x665 (above i_peak) immediately on entering ON -> pwm high for exactly 8 cycles.
REQ-025 SHALL cover max-on fault: iest_coil held at 0x7FF (0 A), enable=1 -> pwm high for 240 cycles, then fault=1 and state=3; fault_clr with enable=1 has no effect; fault_clr with enable=0 -> state=0.
REQ-026 SHALL cover reset mid-pulse: reset_n low for 3 cycles during ON -> pwm=0 immediately; state, fault and pulse_cnt read 0; the block restarts in ON on the second clk edge after reset_n rises.
REQ-027 SHALL cover negative-current clamp: iest_coil=0x900 with i_valley=0 -> treated as 0 A, so pwm turns on after MIN_OFF.
